// File: rtl/evp_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the polynomial evaluation
// accelerator instruction sequencer.
package evp_pkg;

  localparam logic [1:0] OP_STP = 2'b00;
  localparam logic [1:0] OP_EVP = 2'b01;
  localparam logic [1:0] OP_EVB = 2'b10;
  localparam logic [1:0] OP_RST = 2'b11;

  localparam logic [31:0] STATUS_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_WR_RES  = 3'd5,
    S_WR_STAT = 3'd6
  } state_t;

  // Ceiling log2; used to size pointers and counters from depth parameters.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/evp_watchdog.sv
// Per-instruction watchdog: cleared when an instruction issues, counts while the
// sequencer waits, and flags the last permitted wait cycle.
module evp_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = evp_pkg::log2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // The flag rises in the TIMEOUT-th wait cycle, so WAIT never lasts longer than TIMEOUT cycles.
  assign timeout_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/evp_instr_sequencer.sv
// Instruction sequencer: fetches instruction words, dispatches them to the STP/EVP/EVB/RST
// units, collects results and status into the output FIFO and owns the data-buffer pointer.
module evp_instr_sequencer
  import evp_pkg::*;
#(
  parameter int  buffer_size = 1024,
  parameter int  word_size   = 16,
  parameter int  TIMEOUT     = 255,
  localparam int AW          = log2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_empty,
  output logic                 instr_rd_en,
  input  logic [word_size-1:0] instr_in,
  output logic                 start_stp,
  output logic                 start_evp,
  output logic                 start_evb,
  output logic                 start_rst,
  output logic [2:0]           A_out,
  output logic [4:0]           N_out,
  output logic                 rst_instr,
  input  logic                 done_stp,
  input  logic                 done_evp,
  input  logic                 done_evb,
  input  logic                 done_rst,
  input  logic [31:0]          result_evp,
  input  logic [31:0]          result_evb,
  input  logic [31:0]          status_evp,
  input  logic [31:0]          status_evb,
  input  logic [31:0]          status_stp,
  output logic [AW-1:0]        rd_addr_data,
  input  logic [AW-1:0]        rd_addr_data_updated,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [31:0]          out_data,
  output logic [15:0]          instr_count,
  output logic                 busy,
  output state_t               dbg_state
);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [2:0]    a_q, a_d;
  logic [4:0]    n_q, n_d;
  logic [31:0]   res_q, res_d;
  logic [31:0]   stat_q, stat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;

  logic        unit_done;
  logic [31:0] unit_res;
  logic [31:0] unit_stat;
  logic        data_op;
  logic        wd_timeout;
  logic        unused_instr_bits;

  // Bits [10:5] of the instruction word carry no field for the sequencer.
  assign unused_instr_bits = ^instr_in[10:5];

  assign data_op      = (op_q == OP_EVP) || (op_q == OP_EVB);
  assign A_out        = a_q;
  assign N_out        = n_q;
  assign rd_addr_data = addr_q;
  assign instr_count  = cnt_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

  evp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == S_ISSUE),
    .en_i      (state_q == S_WAIT),
    .timeout_o (wd_timeout)
  );

  // Output FIFO handshake: a word is transferred in every cycle where out_wr_en is high;
  // out_wr_en is only raised while out_full is low, and out_data holds the word until it goes.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    n_d         = n_q;
    res_d       = res_q;
    stat_d      = stat_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    instr_rd_en = 1'b0;
    start_stp   = 1'b0;
    start_evp   = 1'b0;
    start_evb   = 1'b0;
    start_rst   = 1'b0;
    rst_instr   = 1'b1;
    out_wr_en   = 1'b0;
    out_data    = '0;
    unit_done   = 1'b0;
    unit_res    = '0;
    unit_stat   = '0;

    // Only the issued unit's done is listened to; RST reports no status of its own.
    case (op_q)
      OP_STP: begin
        unit_done = done_stp;
        unit_stat = status_stp;
      end
      OP_EVP: begin
        unit_done = done_evp;
        unit_res  = result_evp;
        unit_stat = status_evp;
      end
      OP_EVB: begin
        unit_done = done_evb;
        unit_res  = result_evb;
        unit_stat = status_evb;
      end
      default: unit_done = done_rst;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!instr_empty && !rst) begin
          instr_rd_en = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instr_in[15:14];
        a_d     = instr_in[13:11];
        n_d     = (instr_in[15:14] == OP_STP) ? instr_in[4:0] : 5'd0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        case (op_q)
          OP_STP:  start_stp = 1'b1;
          OP_EVP:  start_evp = 1'b1;
          OP_EVB:  start_evb = 1'b1;
          default: begin
            start_rst = 1'b1;
            rst_instr = 1'b0;
            addr_d    = '0;
          end
        endcase
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done) begin
          res_d  = unit_res;
          stat_d = unit_stat;
          if (data_op) addr_d = rd_addr_data_updated;
          state_d = data_op ? S_WR_RES : S_WR_STAT;
        end else if (wd_timeout) begin
          res_d   = '0;
          stat_d  = STATUS_TIMEOUT;
          state_d = data_op ? S_WR_RES : S_WR_STAT;
        end
      end
      S_WR_RES: begin
        out_data = res_q;
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = S_WR_STAT;
        end
      end
      S_WR_STAT: begin
        out_data = stat_q;
        if (!out_full) begin
          out_wr_en = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_STP;
      a_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      stat_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      n_q     <= n_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
